fetch_line_buf: RTL and testbench
=================================

FETCH_LINE_BUF -- requirements
Module: fetch_line_buf

Interface
REQ-001 SHALL provide: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: pc  input  16  fetch byte address from IF stage; bit 0 ignored.
REQ-004 SHALL provide: fetch_en  input  1  IF requests an instruction this cycle.
REQ-005 SHALL provide: flush  input  1  invalidate buffered line.
REQ-006 SHALL provide: instruction  output  16  fetched instruction word.
REQ-007 SHALL provide: inst_valid  output  1  instruction valid this cycle.
REQ-008 SHALL provide: freeze  output  1  stall request to IF stage; IF holds pc while high.
REQ-009 SHALL provide: mem_addr  output  16  backing-memory byte address.
REQ-010 SHALL provide: mem_rd  output  1  one-cycle read strobe to backing memory.
REQ-011 SHALL provide: mem_data  input  16  read data from backing memory.
REQ-012 SHALL provide: mem_data_valid  input  1  mem_data valid; arbitrary latency >= 1 cycle after mem_rd.

Function
REQ-013 SHALL hold one 4-word line: 4x16 data, 13-bit tag (pc[15:3]), one valid bit.
REQ-014 Hit = state IDLE, fetch_en, valid, tag == pc[15:3], flush low; SHALL drive instruction = word[pc[2:1]], inst_valid=1, freeze=0 combinationally, zero latency.
REQ-015 Miss = state IDLE, fetch_en, not hit; SHALL drive freeze=1, inst_valid=0 same cycle, latch fill base {pc[15:3],3'b000}, go FILL next edge.
REQ-016 fetch_en low in IDLE: inst_valid=0, freeze=0, no fill started.
REQ-017 FSM states IDLE, FILL, WAIT, DONE; FILL: mem_rd=1 one cycle, mem_addr=base+2*k, next WAIT.
REQ-018 WAIT: on mem_data_valid store word[k]; k==3 -> DONE else k+1 -> FILL; else stay.
REQ-019 DONE: set valid, tag=base[15:3] unless flush seen during fill; next IDLE; freeze=1.
REQ-020 freeze SHALL be 1 in every cycle of FILL, WAIT, DONE; inst_valid 0 in those states.
REQ-021 mem_data_valid outside WAIT SHALL be ignored.
REQ-022 Word counter k 2 bits; base address never incremented, so line 0xFFF8-0xFFFE fills without wrap past 0xFFFE.
REQ-023 pc change during fill SHALL NOT abort fill; lookup re-evaluated in IDLE.
REQ-024 flush in IDLE clears valid next edge and forces miss that cycle; flush during fill sets sticky flag so DONE leaves valid=0.
REQ-025 mem_addr, mem_rd SHALL be 0 outside FILL; instruction 16'h0000 when inst_valid=0.

Reset
REQ-026 rst low SHALL immediately force IDLE, valid=0, k=0, flush flag=0, mem_rd=0, freeze=0, inst_valid=0, instruction=0.
REQ-027 rst mid-fill SHALL abort; partial line discarded; late mem_data_valid ignored.

Configuration
REQ-028 With FETCH_PERF_EN defined SHALL add output miss_count (16-bit) incremented on each IDLE->FILL transition, saturating at 16'hFFFF, reset 0; without it port and counter absent.

Structure
REQ-029 Shared package fetch_pkg SHALL hold state encoding, LINE_WORDS=4, TAG_W=13.
REQ-030 Data storage SHALL be sub-module line_ram (4x16, one write port, one combinational read port).

Verification
REQ-031 Reset, pc=0, fetch_en=1, memory returns 0x1111..0x4444 with 3-cycle latency -> freeze high 14 cycles, then inst_valid=1, instruction=0x1111.
REQ-032 After fill, pc=2,4,6 consecutive -> instruction 0x2222,0x3333,0x4444 with freeze=0, no mem_rd.
REQ-033 pc=8 after fill -> miss, mem_rd pulses at 0x0008,0x000A,0x000C,0x000E.
REQ-034 flush asserted during WAIT -> fill completes, next access to same pc misses again.
REQ-035 rst low during second WAIT -> freeze=0, mem_rd=0 immediately; pc=0 after release misses.
REQ-036 pc=0xFFFE -> mem_addr sequence 0xFFF8..0xFFFE, instruction = word[3]; with FETCH_PERF_EN miss_count=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and sizing for the fetch line buffer: FSM encoding, line geometry.
// Latency: n/a (package only). Backpressure: n/a.
package fetch_pkg;

  localparam int LINE_WORDS = 4;
  localparam int TAG_W      = 13;
  localparam int WORD_W     = 16;
  localparam int IDX_W      = $clog2(LINE_WORDS);

  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Byte address of word k in the line; base is never incremented, so no wrap.
  function automatic logic [WORD_W-1:0] word_addr(input logic [TAG_W-1:0] base,
                                                   input logic [IDX_W-1:0] k);
    return {base, k, 1'b0};
  endfunction

endpackage

// File: rtl/line_ram.sv
// One-line data store: 4x16 words, single write port, combinational read port.
// Latency: write on rising edge, read zero-cycle. Backpressure: none.
module line_ram
  import fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [WORD_W-1:0]    wdata,
  input  logic [IDX_W-1:0]     raddr,
  output logic [WORD_W-1:0]    rdata
);

  logic [WORD_W-1:0] mem [LINE_WORDS];

  // Contents are qualified by the line valid bit upstream, so no reset here.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_line_buf.sv
// Single-line instruction buffer: zero-latency hit, 4-word refill from backing memory on miss.
// Latency: hit 0 cycles; miss stalls IF via freeze until refill completes. Optional FETCH_PERF_EN adds miss_count.
// Backpressure: freeze holds the IF stage; memory side has no backpressure, one read outstanding at a time.
module fetch_line_buf
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        pc,
  input  logic               fetch_en,
  input  logic               flush,
  output logic [15:0]        instruction,
  output logic               inst_valid,
  output logic               freeze,
  output logic [15:0]        mem_addr,
  output logic               mem_rd,
  input  logic [15:0]        mem_data,
  input  logic               mem_data_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        miss_count
`endif
);

  state_t              state;
  state_t              state_nxt;
  logic [TAG_W-1:0]    tag;
  logic [TAG_W-1:0]    base;
  logic [IDX_W-1:0]    k;
  logic                valid;
  logic                flush_seen;
  logic                hit;
  logic                miss;
  logic                ram_we;
  logic [WORD_W-1:0]   ram_rdata;
  logic                unused_pc_lsb;

  assign unused_pc_lsb = pc[0];

  // rst gates lookup so freeze drops the instant reset asserts.
  assign hit  = rst && (state == S_IDLE) && fetch_en && valid &&
                (tag == pc[15:3]) && !flush;
  assign miss = rst && (state == S_IDLE) && fetch_en && !hit;

  assign ram_we = (state == S_WAIT) && mem_data_valid;

  line_ram u_line_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (k),
    .wdata (mem_data),
    .raddr (pc[2:1]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (miss) state_nxt = S_FILL;
      S_FILL: state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_data_valid) begin
          state_nxt = (k == LAST_WORD) ? S_DONE : S_FILL;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    freeze      = 1'b0;
    inst_valid  = 1'b0;
    instruction = 16'h0000;
    mem_rd      = 1'b0;
    mem_addr    = 16'h0000;
    if (rst) begin
      case (state)
        S_IDLE: begin
          freeze      = miss;
          inst_valid  = hit;
          instruction = hit ? ram_rdata : 16'h0000;
        end
        S_FILL: begin
          freeze   = 1'b1;
          mem_rd   = 1'b1;
          mem_addr = word_addr(base, k);
        end
        S_WAIT, S_DONE: freeze = 1'b1;
        default: freeze = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base       <= '0;
      k          <= '0;
      tag        <= '0;
      valid      <= 1'b0;
      flush_seen <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush) valid <= 1'b0;
          if (miss) begin
            base       <= pc[15:3];
            k          <= '0;
            flush_seen <= 1'b0;
          end
        end
        S_FILL: begin
          if (flush) flush_seen <= 1'b1;
        end
        S_WAIT: begin
          if (flush) flush_seen <= 1'b1;
          if (mem_data_valid && (k != LAST_WORD)) k <= k + 1'b1;
        end
        S_DONE: begin
          // A flush at any point of the refill, including this cycle, leaves the line invalid.
          valid      <= !(flush_seen || flush);
          tag        <= base;
          k          <= '0;
          flush_seen <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_count <= 16'h0000;
    end else if (miss && (miss_count != 16'hFFFF)) begin
      miss_count <= miss_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_line_buf.sv
// Directed bench for fetch_line_buf: scoreboard queues for instructions and memory reads.
module tb_fetch_line_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        fetch_en;
  logic        flush;
  logic [15:0] instruction;
  logic        inst_valid;
  logic        freeze;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic        mem_data_valid;
`ifdef FETCH_PERF_EN
  logic [15:0] miss_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_inst[$];
  logic [15:0] exp_addr[$];

  always #5 clk = ~clk;

  fetch_line_buf dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .fetch_en       (fetch_en),
    .flush          (flush),
    .instruction    (instruction),
    .inst_valid     (inst_valid),
    .freeze         (freeze),
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_data       (mem_data),
    .mem_data_valid (mem_data_valid)
`ifdef FETCH_PERF_EN
    ,
    .miss_count     (miss_count)
`endif
  );

  // Memory image: line at base B holds {1111,2222,3333,4444} ^ B.
  function automatic logic [15:0] mdata(input logic [15:0] a);
    logic [15:0] w;
    case (a[2:1])
      2'd0: w = 16'h1111;
      2'd1: w = 16'h2222;
      2'd2: w = 16'h3333;
      default: w = 16'h4444;
    endcase
    return w ^ {a[15:3], 3'b000};
  endfunction

  // Data is valid in the third cycle counting the strobe cycle.
  initial begin
    logic [15:0] a;
    mem_data_valid = 1'b0;
    mem_data       = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_rd) begin
        a = mem_addr;
        @(posedge clk);
        @(posedge clk);
        #1;
        mem_data       = mdata(a);
        mem_data_valid = 1'b1;
        @(posedge clk);
        #1;
        mem_data_valid = 1'b0;
        mem_data       = 16'h0000;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an instruction or a read strobe.
  always @(negedge clk) begin
    logic [15:0] e;
    if (inst_valid) begin
      checks++;
      if (exp_inst.size() == 0) begin
        errors++;
        $display("FAIL inst_unexpected: got %h freeze=%b, none expected", instruction, freeze);
      end else begin
        e = exp_inst.pop_front();
        if (instruction !== e || freeze !== 1'b0) begin
          errors++;
          $display("FAIL inst: got %h freeze=%b, expected %h freeze=0", instruction, freeze, e);
        end
      end
    end else begin
      checks++;
      if (instruction !== 16'h0000) begin
        errors++;
        $display("FAIL inst_idle_zero: got %h, expected 0000", instruction);
      end
    end
    if (mem_rd) begin
      checks++;
      if (exp_addr.size() == 0) begin
        errors++;
        $display("FAIL mem_rd_unexpected: addr %h, none expected", mem_addr);
      end else begin
        e = exp_addr.pop_front();
        if (mem_addr !== e || freeze !== 1'b1) begin
          errors++;
          $display("FAIL mem_addr: got %h freeze=%b, expected %h freeze=1", mem_addr, freeze, e);
        end
      end
    end else begin
      checks++;
      if (mem_addr !== 16'h0000) begin
        errors++;
        $display("FAIL mem_addr_idle_zero: got %h, expected 0000", mem_addr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_line(input logic [15:0] b);
    for (int i = 0; i < 4; i++) exp_addr.push_back(b + 16'(2 * i));
  endtask

  // Counts freeze cycles until inst_valid; returns just after the next rising edge.
  task automatic wait_valid(output int fz);
    bit done = 0;
    fz = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        done = 1;
        break;
      end
      if (freeze) fz++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_valid_timeout: no inst_valid in 200 cycles, pc=%h", pc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] a, input logic [15:0] e, output int fz);
    pc       = a;
    fetch_en = 1'b1;
    exp_inst.push_back(e);
    wait_valid(fz);
  endtask

  task automatic wait_mem_rd(inout int fz);
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (freeze) fz++;
      if (mem_rd) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_mem_rd_timeout: no mem_rd in 100 cycles");
    end
  endtask

  initial begin
    int fz;
    int fz2;
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fz;
    int fz2;
    rst      = 1'b0;
    pc       = 16'h0000;
    fetch_en = 1'b1;
    flush    = 1'b0;
    #2;
    chk("rst_freeze", freeze, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_mem_rd", mem_rd, 0);
    fetch_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Cold miss on line 0, then hits within the line.
    push_line(16'h0000);
    fetch(16'h0000, 16'h1111, fz);
    chk("fill_freeze_cycles", fz, 14);
    fetch(16'h0002, 16'h2222, fz);
    chk("hit2_freeze", fz, 0);
    fetch(16'h0004, 16'h3333, fz);
    chk("hit4_freeze", fz, 0);
    fetch(16'h0006, 16'h4444, fz);
    chk("hit6_freeze", fz, 0);

    // fetch_en low: nothing happens even on a non-resident pc.
    fetch_en = 1'b0;
    pc       = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("noreq_freeze", freeze, 0);
      chk("noreq_inst_valid", inst_valid, 0);
    end
    @(posedge clk);
    #1;

    // Miss on the next line.
    push_line(16'h0008);
    fetch(16'h0008, 16'h1119, fz);
    chk("miss8_freeze_cycles", fz, 14);

    // Flush during WAIT: fill completes but the line stays invalid, so it refills.
    pc       = 16'h0010;
    fetch_en = 1'b1;
    push_line(16'h0010);
    push_line(16'h0010);
    exp_inst.push_back(16'h1101);
    fz = 0;
    wait_mem_rd(fz);
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    if (freeze) fz++;
    @(posedge clk);
    #1 flush = 1'b0;
    wait_valid(fz2);
    chk("flush_refill_freeze_cycles", fz + fz2, 28);

    // Reset during the second WAIT aborts the fill; late data is ignored.
    pc       = 16'h0020;
    fetch_en = 1'b1;
    exp_addr.push_back(16'h0020);
    exp_addr.push_back(16'h0022);
    fz = 0;
    wait_mem_rd(fz);
    wait_mem_rd(fz);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_freeze", freeze, 0);
    chk("abort_mem_rd", mem_rd, 0);
    chk("abort_inst_valid", inst_valid, 0);
    fetch_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    push_line(16'h0000);
    fetch(16'h0000, 16'h1111, fz);
    chk("post_reset_miss_freeze", fz, 14);

    // Top-of-memory line: no wrap past 0xFFFE.
    fetch_en = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    push_line(16'hFFF8);
    fetch(16'hFFFE, 16'hBBBC, fz);
    chk("top_line_freeze", fz, 14);
`ifdef FETCH_PERF_EN
    chk("miss_count", miss_count, 1);
`endif

    // Flush in IDLE on a resident pc forces a miss that same cycle.
    push_line(16'hFFF8);
    exp_inst.push_back(16'hBBBC);
    pc       = 16'hFFFE;
    fetch_en = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    chk("idle_flush_freeze", freeze, 1);
    chk("idle_flush_inst_valid", inst_valid, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    wait_valid(fz);
    chk("idle_flush_refill_freeze", fz, 13);

    fetch_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("inst_queue_empty", exp_inst.size(), 0);
    chk("addr_queue_empty", exp_addr.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
